// File: rtl/output_port_allocator_if.sv
// Bundle of the allocator's request/grant and flow-control signals.
//
// Handshake: req_i[i] acts as "valid" for input i's head flit and out_ack_i
// as "ready" from the downstream neighbour. A flit moves only on a cycle
// where the owner's req_i and out_ack_i are both high (xfer_o). ack_o[i]
// is the per-input accept. Valid must not depend on ack within a cycle.
interface output_port_allocator_if #(
  parameter int N_IN  = 4,
  parameter int LEN_W = 4,
  parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
);
  logic [N_IN-1:0]       req_i;
  logic [N_IN-1:0]       is_hdr_i;
  logic [N_IN*LEN_W-1:0] tail_len_i;
  logic                  out_ack_i;
  logic [N_IN-1:0]       grant_o;
  logic [SEL_W-1:0]      sel_o;
  logic [N_IN-1:0]       ack_o;
  logic                  xfer_o;
  logic                  busy_o;
  // debug visibility: FSM state (1 = LOCKED) and round-robin pointer
  logic                  state_o;
  logic [SEL_W-1:0]      ptr_o;

  modport master (
    output req_i, is_hdr_i, tail_len_i, out_ack_i,
    input  grant_o, sel_o, ack_o, xfer_o, busy_o, state_o, ptr_o
  );

  modport slave (
    input  req_i, is_hdr_i, tail_len_i, out_ack_i,
    output grant_o, sel_o, ack_o, xfer_o, busy_o, state_o, ptr_o
  );
endinterface

// File: rtl/output_port_allocator.sv
// Per-output wormhole allocator: round-robin among inputs presenting a
// HEADER for this output, then locks to the winner for header + tail_length
// flits. The pointer advances only when a packet completes.
module output_port_allocator #(
  parameter int N_IN  = 4,
  parameter int LEN_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  output_port_allocator_if.slave bus
);
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel;
  logic [N_IN-1:0]  grant;
  // one wider than tail_length so 2^LEN_W-1 + 1 fits
  logic [LEN_W:0]   cnt;

  logic [N_IN-1:0]  cand;
  logic             found;
  logic [SEL_W-1:0] win;
  logic [LEN_W-1:0] win_len;
  logic             xfer;
  int               idx;

  assign cand = bus.req_i & bus.is_hdr_i;

  // Rotating priority scan starting at ptr; first candidate wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_IN; k++) begin
      idx = (int'(ptr) + k) % N_IN;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = SEL_W'(idx);
      end
    end
  end

  assign win_len = bus.tail_len_i[win*LEN_W +: LEN_W];
  assign xfer    = (state == LOCKED) & bus.req_i[sel] & bus.out_ack_i;

  // Next-state: grab on any header candidate, release on the last flit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOCKED;
      LOCKED:  if (xfer && cnt == CNT_ONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant, select, flit counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      sel   <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        grant <= N_IN'(1) << win;
        sel   <= win;
        cnt   <= (LEN_W+1)'(win_len) + CNT_ONE;
      end
    end else if (xfer) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        grant <= '0;
        ptr   <= (sel == SEL_W'(N_IN-1)) ? '0 : sel + SEL_W'(1);
      end
    end
  end

  assign bus.grant_o = grant;
  assign bus.sel_o   = sel;
  assign bus.busy_o  = (state == LOCKED);
  assign bus.xfer_o  = xfer;
  assign bus.ack_o   = grant & {N_IN{xfer}};
  assign bus.state_o = state;
  assign bus.ptr_o   = ptr;
endmodule

// File: tb/tb_output_port_allocator.sv
// Bench for output_port_allocator: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// packet-level model (owner, flits remaining, pointer).
module tb_output_port_allocator;
  localparam int N = 4;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  output_port_allocator_if #(.N_IN(N), .LEN_W(L)) bus();

  output_port_allocator #(.N_IN(N), .LEN_W(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] hdr,
                       input logic [N*L-1:0] tl, input logic ack);
    bus.req_i      = req;
    bus.is_hdr_i   = hdr;
    bus.tail_len_i = tl;
    bus.out_ack_i  = ack;
  endtask

  function automatic logic [N*L-1:0] tl_at(input int port, input int len);
    logic [N*L-1:0] v;
    v = '0;
    v[port*L +: L] = L'(len);
    return v;
  endfunction

  // ---------------- model + scoreboard ----------------
  logic [N-1:0] exp_q[$];   // expected grant owners, in order
  int  m_owner = -1;        // -1 when idle
  int  m_rem   = 0;         // flits left in the packet
  int  m_ptr   = 0;
  int  m_sel   = 0;
  bit  m_valid = 1'b0;
  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin
    logic [N-1:0] e_grant;
    logic         e_xfer;
    logic [N-1:0] popped;
    int w;
    e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e_xfer  = (m_owner >= 0) && bus.req_i[m_owner] && bus.out_ack_i;
    if (m_valid) begin
      chk("grant", 32'(bus.grant_o), 32'(e_grant));
      chk("sel",   32'(bus.sel_o),   32'(m_sel));
      chk("busy",  32'(bus.busy_o),  32'(m_owner >= 0));
      chk("xfer",  32'(bus.xfer_o),  32'(e_xfer));
      chk("ack",   32'(bus.ack_o),   32'(e_xfer ? e_grant : '0));
      chk("ptr",   32'(bus.ptr_o),   32'(m_ptr));
      if (bus.grant_o != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) chk("grant_q_empty", 32'(bus.grant_o), 32'(0));
        else begin
          popped = exp_q.pop_front();
          chk("grant_order", 32'(bus.grant_o), 32'(popped));
        end
      end
    end
    prev_grant = bus.grant_o;
    // advance the model to what the coming edge must produce
    if (rst) begin
      m_owner = -1; m_rem = 0; m_ptr = 0; m_sel = 0; m_valid = 1'b1;
      exp_q.delete();
    end else if (m_valid) begin
      if (m_owner < 0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (w < 0 && bus.req_i[i] && bus.is_hdr_i[i]) w = i;
        end
        if (w >= 0) begin
          m_owner = w;
          m_sel   = w;
          m_rem   = int'(bus.tail_len_i[w*L +: L]) + 1;
          exp_q.push_back(N'(1) << w);
        end
      end else if (e_xfer) begin
        m_rem--;
        if (m_rem == 0) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    int order[$];
    logic [N-1:0] pg;
    logic [1:0] ack_pat [5];
    drive('0, '0, '0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_grant", 32'(bus.grant_o), 32'(0));
    chk("reset_busy",  32'(bus.busy_o),  32'(0));
    chk("reset_ptr",   32'(bus.ptr_o),   32'(0));

    // single WEST packet, tail_length 3
    drive(4'b1000, 4'b1000, tl_at(3, 3), 1'b1);
    chk("t1_no_xfer_arb", 32'(bus.xfer_o), 32'(0));
    tick();
    chk("t1_grant", 32'(bus.grant_o), 32'(4'b1000));
    chk("t1_sel",   32'(bus.sel_o),   32'(3));
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.xfer_o) n++;
      tick();
    end
    drive('0, '0, '0, 1'b1);
    chk("t1_xfers", 32'(n), 32'(4));
    chk("t1_busy_after", 32'(bus.busy_o), 32'(0));
    chk("t1_ptr", 32'(bus.ptr_o), 32'(0));

    // contention NORTH vs EAST, header-only
    drive(4'b0101, 4'b0101, '0, 1'b1);
    tick();
    chk("t2_first", 32'(bus.grant_o), 32'(4'b0001));
    tick();
    drive(4'b0100, 4'b0100, '0, 1'b1);
    chk("t2_bubble", 32'(bus.busy_o), 32'(0));
    tick();
    chk("t2_second", 32'(bus.grant_o), 32'(4'b0100));
    tick();
    drive('0, '0, '0, 1'b1);
    chk("t2_ptr", 32'(bus.ptr_o), 32'(3));

    // backpressure on SOUTH, tail_length 2
    ack_pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
    drive(4'b0010, 4'b0010, tl_at(1, 2), 1'b1);
    tick();
    n = 0;
    for (int k = 0; k < 5; k++) begin
      bus.out_ack_i = ack_pat[k][0];
      #1;
      chk("t3_grant_held", 32'(bus.grant_o), 32'(4'b0010));
      chk("t3_ack", 32'(bus.ack_o), 32'(ack_pat[k][0] ? 4'b0010 : 4'b0000));
      if (bus.xfer_o) n++;
      tick();
    end
    drive('0, '0, '0, 1'b1);
    chk("t3_xfers", 32'(n), 32'(3));
    chk("t3_release", 32'(bus.grant_o), 32'(0));

    // non-header ignored, then max length on EAST
    drive(4'b0100, 4'b0000, tl_at(2, 15), 1'b1);
    tick(); tick();
    chk("t4_nohdr_busy", 32'(bus.busy_o), 32'(0));
    bus.is_hdr_i = 4'b0100;
    tick();
    n = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.xfer_o) n++;
      tick();
    end
    drive('0, '0, '0, 1'b1);
    chk("t4_max_xfers", 32'(n), 32'(16));
    chk("t4_max_busy", 32'(bus.busy_o), 32'(0));

    // reset mid-packet on NORTH
    drive(4'b0001, 4'b0001, tl_at(0, 3), 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_grant", 32'(bus.grant_o), 32'(0));
    chk("t5_rst_ack",   32'(bus.ack_o),   32'(0));
    chk("t5_rst_ptr",   32'(bus.ptr_o),   32'(0));
    rst = 1'b0;
    tick();
    chk("t5_regrant", 32'(bus.grant_o), 32'(4'b0001));
    for (int k = 0; k < 4; k++) tick();
    drive('0, '0, '0, 1'b1);
    tick();

    // round-robin fairness from ptr 0, all inputs, tail_length 1
    rst = 1'b1; tick(); rst = 1'b0;
    drive(4'b1111, 4'b1111, {4'd1, 4'd1, 4'd1, 4'd1}, 1'b1);
    pg = '0;
    for (int c = 0; c < 40 && order.size() < 8; c++) begin
      if (bus.grant_o != '0 && pg == '0)
        for (int i = 0; i < N; i++) if (bus.grant_o[i]) order.push_back(i);
      pg = bus.grant_o;
      tick();
    end
    chk("t6_grants_seen", 32'(order.size()), 32'(8));
    for (int i = 0; i < order.size(); i++) chk("t6_rr_order", 32'(order[i]), 32'(i % 4));

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(N'($urandom | $urandom), N'($urandom), (N*L)'($urandom),
            ($urandom_range(0, 3) != 0));
      tick();
    end
    rst = 1'b0;
    drive(4'b1111, 4'b0000, '0, 1'b1);
    for (int c = 0; c < 40; c++) tick();
    chk("drain_busy", 32'(bus.busy_o), 32'(0));
    chk("drain_queue", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
